// File: rtl/regfile_write_port.sv
// Write side of the 32 x 32-bit register file: storage, one-hot write decode,
// register 0 hardwired to zero, and a scrub engine that clears one register per
// cycle on request. The whole array is driven out to the read-side word mux.
module regfile_write_port #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        WE,
  input  logic [AW-1:0]               WADDR,
  input  logic [WIDTH-1:0]            WDATA,
  input  logic                        CLR,
  output logic [DEPTH-1:0][WIDTH-1:0] REGS,
  output logic                        BUSY,
  output logic                        WACK
);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [DEPTH-1:0]  wen;
  logic [DEPTH-1:0]  clren;
  logic              accept;

  // A write is taken only when idle and no scrub is being requested; CLR wins.
  assign accept = (state == IDLE) && WE && !CLR;

  // One-hot enables: the write decoder and the scrub pointer decoder.
  always_comb begin
    wen   = '0;
    clren = '0;
    if (accept) begin
      wen[WADDR] = 1'b1;
    end
    if (state == SCRUB) begin
      clren[cnt] = 1'b1;
    end
  end

  // Register storage; entry 0 is forced to zero so writes to it are discarded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset || clren[i] || (i == 0)) begin
        REGS[i] <= '0;
      end else if (wen[i]) begin
        REGS[i] <= WDATA;
      end
    end
  end

  // Control state machine: scrub sequencing, busy flag and write acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      BUSY  <= 1'b0;
      WACK  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          WACK <= accept;
          if (CLR) begin
            state <= SCRUB;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        SCRUB: begin
          WACK <= 1'b0;
          cnt  <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
          WACK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for the register-file write port: writes, register 0,
// back-to-back fills, scrub sequencing, reset during scrub and CLR re-requests.
module tb_regfile_write_port;

  logic                clk;
  logic                reset;
  logic                WE;
  logic [4:0]          WADDR;
  logic [31:0]         WDATA;
  logic                CLR;
  logic [31:0][31:0]   REGS;
  logic                BUSY;
  logic                WACK;

  int testsRun;
  int testsFailed;
  int busyCount;
  logic [31:0] expVal;

  regfile_write_port #(.WIDTH(32), .AW(5), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .WADDR (WADDR),
    .WDATA (WDATA),
    .CLR   (CLR),
    .REGS  (REGS),
    .BUSY  (BUSY),
    .WACK  (WACK)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let one rising edge happen, then return at the falling edge for sampling/driving.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    WE    = 1'b0;
    WADDR = '0;
    WDATA = '0;
    CLR   = 1'b0;
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_wack", 32'(WACK), 32'd0);
    for (int i = 0; i < 32; i++) checkOutput("reset_reg", REGS[i], 32'd0);

    // 1: single write to address 3
    WE = 1'b1; WADDR = 5'd3; WDATA = 32'hFFFFFFFF;
    applyStimulus();
    WE = 1'b0;
    checkOutput("t1_wack", 32'(WACK), 32'd1);
    checkOutput("t1_reg3", REGS[3], 32'hFFFFFFFF);
    for (int i = 0; i < 32; i++) if (i != 3) checkOutput("t1_other", REGS[i], 32'd0);
    applyStimulus();
    checkOutput("t1_wack_drop", 32'(WACK), 32'd0);

    // 2: write 16, then attempt write to 0
    WE = 1'b1; WADDR = 5'd16; WDATA = 32'h00000401;
    applyStimulus();
    checkOutput("t2_wack16", 32'(WACK), 32'd1);
    checkOutput("t2_reg16", REGS[16], 32'h00000401);
    WADDR = 5'd0; WDATA = 32'hDEADBEEF;
    applyStimulus();
    WE = 1'b0;
    checkOutput("t2_wack0", 32'(WACK), 32'd1);
    checkOutput("t2_reg0", REGS[0], 32'd0);
    checkOutput("t2_reg16_hold", REGS[16], 32'h00000401);

    // 3: back-to-back fill
    for (int i = 0; i < 32; i++) begin
      WE = 1'b1; WADDR = 5'(i); WDATA = 32'(i) * 32'h01010101;
      applyStimulus();
      checkOutput("t3_wack", 32'(WACK), 32'd1);
    end
    WE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expVal = (i == 0) ? 32'd0 : 32'(i) * 32'h01010101;
      checkOutput("t3_fill", REGS[i], expVal);
    end

    // 4: CLR together with WE, then walk the scrub
    CLR = 1'b1; WE = 1'b1; WADDR = 5'd5; WDATA = 32'h12345678;
    applyStimulus();
    CLR = 1'b0; WE = 1'b0;
    checkOutput("t4_busy_start", 32'(BUSY), 32'd1);
    checkOutput("t4_wack_clr", 32'(WACK), 32'd0);
    checkOutput("t4_reg5_kept", REGS[5], 32'h05050505);
    busyCount = 1;
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        WE = 1'b1; WADDR = 5'd20; WDATA = 32'hAAAAAAAA;
      end
      applyStimulus();
      WE = 1'b0;
      if (BUSY) busyCount++;
      checkOutput("t4_scrubbed", REGS[k], 32'd0);
      if (k < 31) checkOutput("t4_pending", REGS[k+1], 32'(k + 1) * 32'h01010101);
      if (k == 10) begin
        checkOutput("t4_busy_wack", 32'(WACK), 32'd0);
        checkOutput("t4_busy_reg20", REGS[20], 32'h14141414);
      end
    end
    checkOutput("t4_busy_cycles", 32'(busyCount), 32'd32);
    checkOutput("t4_busy_end", 32'(BUSY), 32'd0);
    for (int i = 0; i < 32; i++) checkOutput("t4_all_zero", REGS[i], 32'd0);

    // 5: reset in the middle of a scrub
    WE = 1'b1; WADDR = 5'd9; WDATA = 32'h00000099;
    applyStimulus();
    WADDR = 5'd15; WDATA = 32'h00000155;
    applyStimulus();
    WE = 1'b0;
    CLR = 1'b1;
    applyStimulus();
    CLR = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus();
    checkOutput("t5_busy_mid", 32'(BUSY), 32'd1);
    checkOutput("t5_reg15_mid", REGS[15], 32'h00000155);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("t5_busy", 32'(BUSY), 32'd0);
    checkOutput("t5_wack", 32'(WACK), 32'd0);
    for (int i = 0; i < 32; i++) checkOutput("t5_reg_zero", REGS[i], 32'd0);
    WE = 1'b1; WADDR = 5'd7; WDATA = 32'h00000077;
    applyStimulus();
    WE = 1'b0;
    checkOutput("t5_wack7", 32'(WACK), 32'd1);
    checkOutput("t5_reg7", REGS[7], 32'h00000077);

    // 6: CLR held throughout the scrub must not restart it
    CLR = 1'b1;
    applyStimulus();
    checkOutput("t6_busy_start", 32'(BUSY), 32'd1);
    busyCount = 1;
    for (int k = 0; k < 40; k++) begin
      applyStimulus();
      if (!BUSY) break;
      busyCount++;
    end
    CLR = 1'b0;
    checkOutput("t6_busy_cycles", 32'(busyCount), 32'd32);
    checkOutput("t6_reg7", REGS[7], 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
